vga_plot_sequencer: RTL



---
 rtl/vga_plot_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_plot_sequencer.sv
// Frame sequencer for the 160x120 trace display: clears the framebuffer, then
// runs each enabled trace source in index order onto the single write port.
module vga_plot_sequencer #(
  parameter int          NUM_SRC  = 2,
  parameter int          WIDTH    = 160,
  parameter int          HEIGHT   = 120,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int          TIMEOUT  = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_SRC-1:0]      src_mask,
  input  logic [8*NUM_SRC-1:0]    src_x,
  input  logic [8*NUM_SRC-1:0]    src_y,
  input  logic [12*NUM_SRC-1:0]   src_color,
  input  logic [NUM_SRC-1:0]      src_finished,
  output logic [NUM_SRC-1:0]      src_enable,
  output logic [NUM_SRC-1:0]      src_reset,
  output logic [7:0]              fb_x,
  output logic [6:0]              fb_y,
  output logic [11:0]             fb_color,
  output logic                    fb_we,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, PREP, DRAW, DRAIN, DONE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         clr_x;
  logic [6:0]         clr_y;
  logic [TO_W-1:0]    draw_cnt;
  logic               drain_cnt;

  logic               s1_valid;
  logic [7:0]         s1_x;
  logic [11:0]        s1_color;

  logic [7:0]         sel_x;
  logic [7:0]         sel_y;
  logic [11:0]        sel_color;
  logic               sel_finished;
  logic               first_found;
  logic [IDX_W-1:0]   first_idx;
  logic               next_found;
  logic [IDX_W-1:0]   next_idx;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_SRC-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Source mux plus lowest-set-bit searches; the descending loop leaves the
  // lowest qualifying index as the final assignment.
  always_comb begin
    sel_x        = '0;
    sel_y        = '0;
    sel_color    = '0;
    sel_finished = 1'b0;
    first_found  = 1'b0;
    first_idx    = '0;
    next_found   = 1'b0;
    next_idx     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (idx == IDX_W'(i)) begin
        sel_x        = src_x[8*i +: 8];
        sel_y        = src_y[8*i +: 8];
        sel_color    = src_color[12*i +: 12];
        sel_finished = src_finished[i];
      end
      if (mask[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (mask[i] && (i > int'(idx))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '0;
      idx        <= '0;
      clr_x      <= '0;
      clr_y      <= '0;
      draw_cnt   <= '0;
      drain_cnt  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_x       <= '0;
      s1_color   <= '0;
      src_enable <= '0;
      src_reset  <= '0;
      fb_x       <= '0;
      fb_y       <= '0;
      fb_color   <= '0;
      fb_we      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done      <= 1'b0;
      src_reset <= '0;
      s1_valid  <= 1'b0;
      // Stage 2: src_y arrives one cycle after its column, so it pairs with stage 1.
      fb_x      <= s1_x;
      fb_color  <= s1_color;
      fb_y      <= sel_y[6:0];
      fb_we     <= s1_valid && (s1_x < 8'(WIDTH)) && (sel_y < 8'(HEIGHT));

      case (state)
        IDLE: begin
          if (start) begin
            mask  <= src_mask;
            err   <= 1'b0;
            clr_x <= '0;
            clr_y <= '0;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end

        CLEAR: begin
          fb_x     <= clr_x;
          fb_y     <= clr_y;
          fb_color <= BG_COLOR;
          fb_we    <= 1'b1;
          if (clr_x == 8'(WIDTH - 1)) begin
            clr_x <= '0;
            if (clr_y == 7'(HEIGHT - 1)) begin
              clr_y <= '0;
              if (first_found) begin
                idx       <= first_idx;
                src_reset <= onehot(first_idx);
                state     <= PREP;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              clr_y <= clr_y + 7'd1;
            end
          end else begin
            clr_x <= clr_x + 8'd1;
          end
        end

        PREP: begin
          draw_cnt   <= '0;
          src_enable <= onehot(idx);
          state      <= DRAW;
        end

        DRAW: begin
          s1_valid <= 1'b1;
          s1_x     <= sel_x;
          s1_color <= sel_color;
          if (sel_finished) begin
            src_enable <= '0;
            drain_cnt  <= 1'b0;
            state      <= DRAIN;
          end else if (draw_cnt == TO_W'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            src_enable <= '0;
            drain_cnt  <= 1'b0;
            state      <= DRAIN;
          end else begin
            draw_cnt <= draw_cnt + 1'b1;
          end
        end

        // idx must hold through the first drain cycle for the last column's y.
        DRAIN: begin
          if (!drain_cnt) begin
            drain_cnt <= 1'b1;
          end else if (next_found) begin
            idx       <= next_idx;
            src_reset <= onehot(next_idx);
            state     <= PREP;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
